// File: rtl/uart_bus_bridge.sv
// Byte-stream command bridge: parses 'W'/'R' frames from usb_uart, runs one bus
// transaction per frame and streams the ACK / read data / NAK back to the host.
module uart_bus_bridge #(
  parameter int unsigned TIMEOUT = 4800000
) (
  input  logic        clk_48mhz,
  input  logic        reset_n,
  input  logic [7:0]  uart_out_data,
  input  logic        uart_out_valid,
  output logic        uart_out_ready,
  output logic [7:0]  uart_in_data,
  output logic        uart_in_valid,
  input  logic        uart_in_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  localparam logic [7:0]  OP_WR   = 8'h57;
  localparam logic [7:0]  OP_RD   = 8'h52;
  localparam logic [7:0]  RSP_ACK = 8'h06;
  localparam logic [7:0]  RSP_NAK = 8'h15;
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic [2:0]  resp_left, resp_left_nxt;
  logic [31:0] resp_sr, resp_sr_nxt;
  logic [23:0] idle_cnt, idle_cnt_nxt;
  logic        bus_we_nxt;
  logic [31:0] bus_addr_nxt, bus_wdata_nxt;
  logic        rx_fire, tx_fire;

  // Handshake outputs decode straight from state so reset clears them at once.
  assign uart_out_ready = (state == IDLE) || (state == ADDR) || (state == DATA);
  assign uart_in_valid  = (state == RESP);
  assign bus_req        = (state == BUS);
  assign uart_in_data   = resp_sr[31:24];
  assign rx_fire        = uart_out_valid & uart_out_ready;
  assign tx_fire        = uart_in_valid & uart_in_ready;

  always_comb begin
    state_nxt     = state;
    byte_cnt_nxt  = byte_cnt;
    resp_left_nxt = resp_left;
    resp_sr_nxt   = resp_sr;
    idle_cnt_nxt  = '0;
    bus_we_nxt    = bus_we;
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
    case (state)
      IDLE: begin
        if (rx_fire) begin
          if (uart_out_data == OP_WR || uart_out_data == OP_RD) begin
            state_nxt    = ADDR;
            byte_cnt_nxt = '0;
            bus_we_nxt   = (uart_out_data == OP_WR);
          end else begin
            state_nxt     = RESP;
            resp_sr_nxt   = {RSP_NAK, 24'h0};
            resp_left_nxt = 3'd1;
          end
        end
      end
      ADDR, DATA: begin
        if (rx_fire) begin
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (state == ADDR) bus_addr_nxt  = {bus_addr[23:0], uart_out_data};
          else               bus_wdata_nxt = {bus_wdata[23:0], uart_out_data};
          if (byte_cnt == 2'd3) state_nxt = (state == ADDR && bus_we) ? DATA : BUS;
        end else if (idle_cnt == TO_LAST) begin
          // Host stalled mid-frame: drop the partial frame silently.
          state_nxt    = IDLE;
          byte_cnt_nxt = '0;
        end else begin
          idle_cnt_nxt = idle_cnt + 24'd1;
        end
      end
      BUS: begin
        if (bus_ack) begin
          state_nxt = RESP;
          if (bus_we) begin
            resp_sr_nxt   = {RSP_ACK, 24'h0};
            resp_left_nxt = 3'd1;
          end else begin
            resp_sr_nxt   = bus_rdata;
            resp_left_nxt = 3'd4;
          end
        end
      end
      RESP: begin
        if (tx_fire) begin
          resp_sr_nxt   = {resp_sr[23:0], 8'h00};
          resp_left_nxt = resp_left - 3'd1;
          if (resp_left == 3'd1) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      resp_left <= '0;
      resp_sr   <= '0;
      idle_cnt  <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      resp_left <= resp_left_nxt;
      resp_sr   <= resp_sr_nxt;
      idle_cnt  <= idle_cnt_nxt;
      bus_we    <= bus_we_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_wdata <= bus_wdata_nxt;
    end
  end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: directed vector table, corner sequences and random
// commands checked against a frame-level reference model.
module tb_uart_bus_bridge;
  localparam int unsigned TO = 16;

  logic        clk_48mhz = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  uart_out_data = '0;
  logic        uart_out_valid = 1'b0;
  logic        uart_out_ready;
  logic [7:0]  uart_in_data;
  logic        uart_in_valid;
  logic        uart_in_ready = 1'b0;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata = '0;
  logic        ack_auto = 1'b0, ack_manual = 1'b0;

  assign bus_ack = ack_auto | ack_manual;

  uart_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk_48mhz(clk_48mhz), .reset_n(reset_n),
    .uart_out_data(uart_out_data), .uart_out_valid(uart_out_valid), .uart_out_ready(uart_out_ready),
    .uart_in_data(uart_in_data), .uart_in_valid(uart_in_valid), .uart_in_ready(uart_in_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  typedef struct {
    logic [7:0] op; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;
    int n; logic [31:0] resp; bit bus; int stall;
  } vec_t;

  txn_t       bus_q[$];
  logic [7:0] rx_q[$];
  int errors = 0, checks = 0, op_wait = 0;

  logic [31:0] cur_rdata = '0;
  int ack_delay = 3, sink_n = 0, gap_max = 0;
  bit ack_rand = 1'b0, spurious = 1'b0, bus_hold = 1'b0, sink_rand = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: what the host must see back, and whether a bus cycle runs.
  function automatic void model(input logic [7:0] op, input logic [31:0] rd,
                                output int n, output logic [31:0] resp, output bit has_bus);
    case (op)
      8'h57:   begin n = 1; resp = {8'h06, 24'h0}; has_bus = 1'b1; end
      8'h52:   begin n = 4; resp = rd;             has_bus = 1'b1; end
      default: begin n = 1; resp = {8'h15, 24'h0}; has_bus = 1'b0; end
    endcase
  endfunction

  // Bus slave: logs each transaction, checks stability, acks after a delay.
  txn_t cur_txn;
  bit   in_txn = 1'b0, post_ack = 1'b0;
  int   ack_cnt = 0;
  always begin
    @(posedge clk_48mhz); #1;
    ack_auto = 1'b0;
    if (post_ack) begin
      post_ack = 1'b0;
      chk("bus_req_after_ack", 72'(bus_req), 72'd0);
    end
    if (!reset_n) in_txn = 1'b0;
    else if (bus_req) begin
      if (!in_txn) begin
        in_txn  = 1'b1;
        cur_txn = '{bus_we, bus_addr, bus_wdata};
        bus_q.push_back(cur_txn);
        ack_cnt = ack_rand ? int'($urandom_range(0, 5)) : ack_delay;
      end else begin
        chk("bus_stable", 72'({bus_we, bus_addr, bus_wdata}),
            72'({cur_txn.we, cur_txn.addr, cur_txn.wdata}));
      end
      if (!bus_hold) begin
        if (ack_cnt == 0) begin
          ack_auto = 1'b1; bus_rdata = cur_rdata; in_txn = 1'b0; post_ack = 1'b1;
        end else ack_cnt--;
      end
    end else begin
      in_txn = 1'b0;
      if (spurious && $urandom_range(0, 3) == 0) begin
        ack_auto = 1'b1; bus_rdata = $urandom;
      end
    end
  end

  // Response sink: stalls each byte stall_tgt cycles and checks it is held meanwhile.
  int         stall = 0, stall_tgt = 0;
  bit         held = 1'b0;
  logic [7:0] held_data = '0;
  always begin
    @(posedge clk_48mhz); #1;
    if (!reset_n) begin
      held = 1'b0; stall = 0; uart_in_ready = 1'b0;
    end else begin
      if (held) begin
        chk("resp_hold_valid", 72'(uart_in_valid), 72'd1);
        chk("resp_hold_data", 72'(uart_in_data), 72'(held_data));
      end
      held = 1'b0;
      if (uart_in_valid) begin
        if (stall < stall_tgt) begin
          uart_in_ready = 1'b0; stall++; held = 1'b1; held_data = uart_in_data;
        end else begin
          uart_in_ready = 1'b1; rx_q.push_back(uart_in_data); stall = 0;
          stall_tgt = sink_rand ? int'($urandom_range(0, 3)) : sink_n;
        end
      end else uart_in_ready = 1'($urandom_range(0, 1));
    end
  end

  // Ready must be high exactly when neither a bus cycle nor a response is in flight.
  always @(negedge clk_48mhz) begin
    if (reset_n) begin
      chk("out_ready_vs_busy", 72'(uart_out_ready), 72'(!(bus_req || uart_in_valid)));
      chk("req_valid_exclusive", 72'(bus_req && uart_in_valid), 72'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, output int waited);
    logic r;
    int   n;
    n = 0;
    uart_out_valid = 1'b1;
    uart_out_data  = b;
    forever begin
      r = uart_out_ready;
      @(posedge clk_48mhz); #1;
      n++;
      if (r) break;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL send_timeout: byte %0h not accepted after %0d cycles", b, n);
        break;
      end
    end
    waited = n;
  endtask

  task automatic gap();
    int g;
    if (gap_max > 0) begin
      g = $urandom_range(0, gap_max);
      if (g > 0) begin
        uart_out_valid = 1'b0;
        repeat (g) begin @(posedge clk_48mhz); #1; end
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    int w;
    send_byte(op, w);
    op_wait = w;
    if (op == 8'h57 || op == 8'h52)
      for (int i = 3; i >= 0; i--) begin gap(); send_byte(a[8*i +: 8], w); end
    if (op == 8'h57)
      for (int i = 3; i >= 0; i--) begin gap(); send_byte(d[8*i +: 8], w); end
  endtask

  task automatic wait_rx(input int n, input string tag);
    int c;
    c = 0;
    while (rx_q.size() < n && c < 500) begin @(posedge clk_48mhz); #1; c++; end
    if (rx_q.size() < n) begin
      checks++; errors++;
      $display("FAIL %s_rx_timeout: got %0d bytes required %0d", tag, rx_q.size(), n);
    end
    repeat (10) begin @(posedge clk_48mhz); #1; end
  endtask

  task automatic do_cmd(input vec_t v, input string tag);
    logic [31:0] r;
    rx_q.delete(); bus_q.delete();
    cur_rdata = v.rdata;
    sink_n = v.stall;
    if (!sink_rand) stall_tgt = v.stall;
    send_frame(v.op, v.addr, v.wdata);
    uart_out_valid = 1'b0;
    wait_rx(v.n, tag);
    r = v.resp;
    chk({tag, "_resp_count"}, 72'(rx_q.size()), 72'(v.n));
    for (int i = 0; i < v.n && i < rx_q.size(); i++)
      chk({tag, "_resp_byte"}, 72'(rx_q[i]), 72'(r[31-8*i -: 8]));
    chk({tag, "_bus_count"}, 72'(bus_q.size()), 72'(v.bus ? 1 : 0));
    if (v.bus && bus_q.size() > 0) begin
      chk({tag, "_bus_we"}, 72'(bus_q[0].we), 72'(v.op == 8'h57));
      chk({tag, "_bus_addr"}, 72'(bus_q[0].addr), 72'(v.addr));
      if (v.op == 8'h57) chk({tag, "_bus_wdata"}, 72'(bus_q[0].wdata), 72'(v.wdata));
    end
  endtask

  initial begin
    vec_t        tbl[7];
    vec_t        v;
    int          w, c, sel;
    logic [39:0] b2b_exp;
    //            op     addr          wdata         rdata         n  resp          bus stall
    tbl[0] = '{8'h57, 32'h12345678, 32'hDEADBEEF, 32'h00000000, 1, 32'h06000000, 1'b1, 0};
    tbl[1] = '{8'h52, 32'h00000010, 32'h00000000, 32'hCAFEF00D, 4, 32'hCAFEF00D, 1'b1, 5};
    tbl[2] = '{8'h41, 32'h00000000, 32'h00000000, 32'h00000000, 1, 32'h15000000, 1'b0, 0};
    tbl[3] = '{8'h52, 32'h80000001, 32'h00000000, 32'h0123ABCD, 4, 32'h0123ABCD, 1'b1, 1};
    tbl[4] = '{8'h77, 32'h00000000, 32'h00000000, 32'h00000000, 1, 32'h15000000, 1'b0, 2};
    tbl[5] = '{8'h57, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1, 32'h06000000, 1'b1, 3};
    tbl[6] = '{8'h00, 32'h00000000, 32'h00000000, 32'h00000000, 1, 32'h15000000, 1'b0, 0};

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk_48mhz);
    #1;
    chk("rst_out_ready", 72'(uart_out_ready), 72'd1);
    chk("rst_in_valid", 72'(uart_in_valid), 72'd0);
    chk("rst_in_data", 72'(uart_in_data), 72'd0);
    chk("rst_bus_req", 72'(bus_req), 72'd0);
    chk("rst_bus_we", 72'(bus_we), 72'd0);
    chk("rst_bus_addr", 72'(bus_addr), 72'd0);
    chk("rst_bus_wdata", 72'(bus_wdata), 72'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_cmd(tbl[i], $sformatf("vec%0d", i));
      if (i == 0) chk("first_cmd_wait", 72'(op_wait), 72'd1);
    end

    // Inter-byte timeout: partial write dropped, following read runs.
    rx_q.delete(); bus_q.delete();
    send_byte(8'h57, w); send_byte(8'h01, w); send_byte(8'h02, w);
    uart_out_valid = 1'b0;
    repeat (TO) begin @(posedge clk_48mhz); #1; end
    chk("to_no_bus", 72'(bus_q.size()), 72'd0);
    chk("to_no_resp", 72'(rx_q.size()), 72'd0);
    do_cmd('{8'h52, 32'h00000004, 32'h0, 32'h5A5AA5A5, 4, 32'h5A5AA5A5, 1'b1, 0}, "timeout_read");

    // Back-to-back write then read with valid held high.
    rx_q.delete(); bus_q.delete();
    cur_rdata = 32'h13579BDF; sink_n = 0; stall_tgt = 0;
    send_frame(8'h57, 32'hA0A0A0A0, 32'h0F0F0F0F);
    send_frame(8'h52, 32'h00000044, 32'h0);
    uart_out_valid = 1'b0;
    wait_rx(5, "b2b");
    b2b_exp = {8'h06, 32'h13579BDF};
    chk("b2b_resp_count", 72'(rx_q.size()), 72'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      chk("b2b_resp_byte", 72'(rx_q[i]), 72'(b2b_exp[39-8*i -: 8]));
    chk("b2b_bus_count", 72'(bus_q.size()), 72'd2);
    if (bus_q.size() == 2) begin
      chk("b2b_wr", 72'({bus_q[0].we, bus_q[0].addr, bus_q[0].wdata}),
          72'({1'b1, 32'hA0A0A0A0, 32'h0F0F0F0F}));
      chk("b2b_rd", 72'({bus_q[1].we, bus_q[1].addr}), 72'({1'b0, 32'h00000044}));
    end

    // Reset while the bus transaction is outstanding.
    rx_q.delete(); bus_q.delete();
    bus_hold = 1'b1;
    send_frame(8'h57, 32'h11112222, 32'h33334444);
    uart_out_valid = 1'b0;
    c = 0;
    while (!bus_req && c < 100) begin @(posedge clk_48mhz); #1; c++; end
    chk("rst_mid_saw_req", 72'(bus_req), 72'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_bus_req", 72'(bus_req), 72'd0);
    chk("rst_mid_in_valid", 72'(uart_in_valid), 72'd0);
    chk("rst_mid_out_ready", 72'(uart_out_ready), 72'd1);
    chk("rst_mid_bus_addr", 72'(bus_addr), 72'd0);
    @(posedge clk_48mhz); #1;
    reset_n = 1'b1; bus_hold = 1'b0;
    ack_manual = 1'b1;
    @(posedge clk_48mhz); #1;
    ack_manual = 1'b0;
    repeat (20) begin @(posedge clk_48mhz); #1; end
    chk("rst_mid_no_resp", 72'(rx_q.size()), 72'd0);
    chk("rst_mid_bus_count", 72'(bus_q.size()), 72'd1);
    do_cmd('{8'h52, 32'hC0DE0000, 32'h0, 32'h89ABCDEF, 4, 32'h89ABCDEF, 1'b1, 0}, "rst_recover");

    // Random commands with random gaps, stalls, ack delays and stray acks.
    spurious = 1'b1; ack_rand = 1'b1; sink_rand = 1'b1; gap_max = 3;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) v.op = 8'h57;
      else if (sel < 9) v.op = 8'h52;
      else begin
        v.op = 8'($urandom);
        while (v.op == 8'h57 || v.op == 8'h52) v.op = 8'($urandom);
      end
      v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom; v.stall = 0;
      model(v.op, v.rdata, v.n, v.resp, v.bus);
      do_cmd(v, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: bench did not complete, errors=%0d", errors);
    $fatal(1);
  end
endmodule

// File: doc/uart_bus_bridge.md
UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
- REQ-001: Parameter TIMEOUT, default 4800000; inter-byte timeout in clk_48mhz cycles (100 ms), legal range 2..2^24-1.
- REQ-002: clk_48mhz  input  1  sole clock, all state on rising edge.
- REQ-003: reset_n  input  1  reset, asynchronous assert, active-low.
- REQ-004: uart_out_data  input  8  host-to-device byte from usb_uart.
- REQ-005: uart_out_valid  input  1  byte available.
- REQ-006: uart_out_ready  output  1  bridge accepts byte.
- REQ-007: uart_in_data  output  8  device-to-host response byte into usb_uart.
- REQ-008: uart_in_valid  output  1  response byte available.
- REQ-009: uart_in_ready  input  1  usb_uart accepts byte.
- REQ-010: bus_req  output  1  bus transaction request.
- REQ-011: bus_we  output  1  1 = write, 0 = read; valid while bus_req.
- REQ-012: bus_addr  output  32  transaction address.
- REQ-013: bus_wdata  output  32  write data.
- REQ-014: bus_ack  input  1  single-cycle completion pulse.
- REQ-015: bus_rdata  input  32  read data, sampled in the bus_ack cycle.

Function
- REQ-016: Byte transfer on either stream only when valid & ready are both high in the same cycle.
- REQ-017: The command frame is: opcode byte, 4 address bytes MSB first, then for writes only 4 data bytes MSB first.
- REQ-018: The opcodes are 0x57 ('W') write and 0x52 ('R') read.
- REQ-019: The FSM states are IDLE, ADDR, DATA, BUS and RESP.
- REQ-020: uart_out_ready SHALL be 1 in IDLE, ADDR and DATA, and 0 in BUS and RESP.
- REQ-021: IDLE: 'W' or 'R' -> ADDR with byte counter cleared.
  - Any other byte -> RESP with the single byte 0x15 (NAK).
- REQ-022: ADDR: shift each byte into bus_addr from the low end.
  - After the 4th byte: 'W' -> DATA, 'R' -> BUS.
- REQ-023: DATA: shift each byte into bus_wdata.
  - After the 4th byte -> BUS.
- REQ-024: BUS: bus_req SHALL be 1 from the first cycle in BUS until and including the bus_ack cycle.
  - bus_addr, bus_we and bus_wdata SHALL be stable throughout.
  - bus_ack received -> RESP; bus_req SHALL be 0 in the following cycle.
- REQ-025: RESP, write: one byte 0x06 (ACK).
- REQ-026: RESP, read: 4 bytes of the captured bus_rdata, MSB first.
- REQ-027: RESP: uart_in_valid SHALL be high and uart_in_data stable until each byte is accepted.
  - After the last byte is accepted -> IDLE in the next cycle.
- REQ-028: Latency: the first response byte is valid in the cycle after the bus_ack cycle, or after the NAK-triggering byte is accepted.
- REQ-029: An idle counter runs in ADDR and DATA, clears on every accepted byte, and increments otherwise.
  - When it reaches TIMEOUT, the FSM SHALL go to IDLE, discard the partial frame, and send no response.
  - The counter is held at 0 in IDLE, BUS and RESP.
- REQ-030: The BUS state has no timeout; the bridge waits indefinitely for bus_ack.
- REQ-031: bus_ack outside the BUS state SHALL be ignored.
- REQ-032: uart_in_valid SHALL be 0 outside RESP.
  - bus_req SHALL be 0 outside BUS.
- REQ-033: Accepting the last response byte and a new uart_out byte in the same cycle is impossible, because ready is 0 in RESP; the new byte waits in usb_uart.

Reset
- REQ-034: reset_n low SHALL immediately force: state IDLE, uart_out_ready 1, uart_in_valid 0, uart_in_data 0x00, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, counters 0.
- REQ-035: Reset asserted mid-frame or mid-transaction SHALL abandon the frame or transaction with no response; an outstanding bus transaction is dropped.
- REQ-036: The first command is accepted in the first cycle after reset_n deasserts.

Verification
- REQ-037: Write command.
  - Stimulus: 57 12 34 56 78 DE AD BE EF, then bus_ack 3 cycles after bus_req.
  - Required: bus_req=1, bus_we=1, bus_addr=0x12345678, bus_wdata=0xDEADBEEF; then one byte 0x06.
- REQ-038: Read command.
  - Stimulus: 52 00 00 00 10, bus_rdata=0xCAFEF00D at bus_ack, uart_in_ready held low for 5 cycles per byte.
  - Required: bytes CA FE F0 0D, each held stable until accepted; then IDLE.
- REQ-039: Bad opcode.
  - Stimulus: byte 0x41.
  - Required: single 0x15, no bus_req; a following valid 'R' frame executes normally.
- REQ-040: Inter-byte timeout with TIMEOUT=16.
  - Stimulus: 57 01 02, then 16 idle cycles, then 52 00 00 00 04.
  - Required: no bus activity and no response for the partial frame; the read to 0x00000004 executes.
- REQ-041: Reset mid-transaction.
  - Stimulus: reset_n low during BUS with bus_req=1.
  - Required: bus_req=0 and uart_in_valid=0 asynchronously; bus_ack after release is ignored; no response is sent.
- REQ-042: Back-to-back commands.
  - Stimulus: a write immediately followed by a read, with uart_out_valid held high.
  - Required: uart_out_ready=0 during BUS/RESP; both commands complete in order; responses 06 then 4 data bytes.
